// File: rtl/sm_dmem_pkg.sv
// Shared types and constants for the data-memory bridge between a simple
// core pipeline and a valid/ready memory bus.
package sm_dmem_pkg;

    // Bridge FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Default abort limit for one access (cycles spent in ADDR + RDATA).
    localparam int TIMEOUT_DEFAULT = 255;

    // Width of the wait counter; limits above 255 are not representable.
    localparam int CNT_W = 8;

    // A bus address is usable only when it is word aligned.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sm_timeout_counter.sv
// Wait counter for one bus access. It is cleared when an access starts and
// counts every cycle the access is outstanding; "expired" flags the last
// permitted cycle so the FSM can abort instead of waiting forever.
module sm_timeout_counter
    import sm_dmem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_p,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over enable; saturate rather than wrap.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The cycle where count reaches limit-1 is the last one allowed.
    assign expired = enable && (count_q == (limit - {{(CNT_W-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/sm_dmem_bridge.sv
// Data-memory bridge: turns a single-cycle core load/store request into a
// valid/ready bus transaction, stalls the core until it completes, and
// reports misaligned or timed-out accesses through err / err_sticky.
module sm_dmem_bridge
    import sm_dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic        err_sticky,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t      state_q,      state_d;
    logic        bus_valid_q,  bus_valid_d;
    logic        bus_write_q,  bus_write_d;
    logic [31:0] bus_addr_q,   bus_addr_d;
    logic [31:0] bus_wdata_q,  bus_wdata_d;
    logic [31:0] rsp_rdata_q,  rsp_rdata_d;
    logic        err_q,        err_d;
    logic        err_sticky_q, err_sticky_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;

    // Outstanding access time: counts only while waiting on the bus.
    assign cnt_enable = (state_q == ADDR) || (state_q == RDATA);

    sm_timeout_counter u_timeout (
        .clk     (clk),
        .rst_p   (rst_p),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (LIMIT),
        .expired (cnt_expired)
    );

    // Next-state and registered-output logic. Completion is tested before
    // expiry so a response on the final cycle is still accepted.
    always_comb begin
        state_d      = state_q;
        bus_valid_d  = bus_valid_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        rsp_rdata_d  = rsp_rdata_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        cnt_clear    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_word_aligned(req_addr)) begin
                        state_d     = ADDR;
                        bus_valid_d = 1'b1;
                        bus_write_d = req_write;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_wdata_d = req_wdata;
                        cnt_clear   = 1'b1;
                    end else begin
                        // Misaligned: never touch the bus.
                        state_d      = ERR;
                        err_d        = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end
            end

            ADDR: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_write_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        rsp_rdata_d = bus_rdata;
                        state_d     = DONE;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (cnt_expired) begin
                    bus_valid_d  = 1'b0;
                    state_d      = ERR;
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                end
            end

            RDATA: begin
                if (bus_rvalid) begin
                    rsp_rdata_d = bus_rdata;
                    state_d     = DONE;
                end else if (cnt_expired) begin
                    state_d      = ERR;
                    err_d        = 1'b1;
                    err_sticky_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q      <= IDLE;
            bus_valid_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rsp_rdata_q  <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_valid_q  <= bus_valid_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rsp_rdata_q  <= rsp_rdata_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Core must hold while a request is pending or the bus is busy.
    always_comb begin
        stall = ((state_q == IDLE) && req_valid) ||
                (state_q == ADDR) || (state_q == RDATA);
    end

    assign bus_valid  = bus_valid_q;
    assign bus_write  = bus_write_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sm_dmem_bridge.sv
// Bench for sm_dmem_bridge: a default-timeout instance (a) driven from a
// vector table, and a TIMEOUT_CYCLES=4 instance (b) sharing the same inputs
// for the timeout corner cases.
module tb_sm_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_p;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        a_stall, a_err, a_sticky, a_bv, a_bw;
    logic [31:0] a_rd, a_ba, a_bwd;
    logic        b_stall, b_err, b_sticky, b_bv, b_bw;
    logic [31:0] b_rd, b_ba, b_bwd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sm_dmem_bridge dut_a (
        .clk(clk), .rst_p(rst_p),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(a_stall), .rsp_rdata(a_rd), .err(a_err), .err_sticky(a_sticky),
        .bus_valid(a_bv), .bus_write(a_bw), .bus_addr(a_ba), .bus_wdata(a_bwd),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    sm_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst_p(rst_p),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(b_stall), .rsp_rdata(b_rd), .err(b_err), .err_sticky(b_sticky),
        .bus_valid(b_bv), .bus_write(b_bw), .bus_addr(b_ba), .bus_wdata(b_bwd),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        rv, wr;
        logic [31:0] addr, wdata;
        logic        rdy, rvld;
        logic [31:0] rdata;
        logic        e_stall, e_bv, e_bw;
        logic [31:0] e_ba, e_bwd;
        logic        e_err, e_sticky;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(
        input logic rv, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
        input logic rdy, input logic rvld, input logic [31:0] rdata,
        input logic e_stall, input logic e_bv, input logic e_bw,
        input logic [31:0] e_ba, input logic [31:0] e_bwd,
        input logic e_err, input logic e_sticky, input logic [31:0] e_rd);
        vec_t v;
        v.rv = rv; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.rdy = rdy; v.rvld = rvld; v.rdata = rdata;
        v.e_stall = e_stall; v.e_bv = e_bv; v.e_bw = e_bw;
        v.e_ba = e_ba; v.e_bwd = e_bwd;
        v.e_err = e_err; v.e_sticky = e_sticky; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_p = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_p = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // columns: rv wr addr wdata rdy rvld rdata | stall bv bw ba bwd err sticky rd
        vecs[0]  = mk(0,0,32'h0,  32'h0,       0,0,32'h0,       0,0,0,32'h0,  32'h0,       0,0,32'h0);
        // aligned load, zero-wait: IDLE -> ADDR -> RDATA -> DONE
        vecs[1]  = mk(1,0,32'h100,32'h0,       0,0,32'h0,       1,0,0,32'h0,  32'h0,       0,0,32'h0);
        vecs[2]  = mk(1,0,32'h100,32'h0,       1,0,32'h0,       1,1,0,32'h100,32'h0,       0,0,32'h0);
        vecs[3]  = mk(1,0,32'h100,32'h0,       0,1,32'hDEADBEEF,1,0,0,32'h100,32'h0,       0,0,32'h0);
        vecs[4]  = mk(1,0,32'h100,32'h0,       0,0,32'h0,       0,0,0,32'h100,32'h0,       0,0,32'hDEADBEEF);
        // stray rvalid in IDLE must not touch rsp_rdata
        vecs[5]  = mk(0,0,32'h0,  32'h0,       0,1,32'h11111111,0,0,0,32'h100,32'h0,       0,0,32'hDEADBEEF);
        // store with bus_ready delayed 4 cycles
        vecs[6]  = mk(1,1,32'h200,32'h12345678,0,0,32'h0,       1,0,0,32'h100,32'h0,       0,0,32'hDEADBEEF);
        vecs[7]  = mk(1,1,32'h200,32'h12345678,0,0,32'h0,       1,1,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[8]  = mk(1,1,32'h200,32'h12345678,0,0,32'h0,       1,1,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[9]  = mk(1,1,32'h200,32'h12345678,0,1,32'hBAD0BAD0,1,1,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[10] = mk(1,1,32'h200,32'h12345678,0,0,32'h0,       1,1,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[11] = mk(1,1,32'h200,32'h12345678,1,1,32'hBAD0BAD0,1,1,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[12] = mk(1,1,32'h200,32'h12345678,0,0,32'h0,       0,0,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[13] = mk(0,0,32'h0,  32'h0,       0,0,32'h0,       0,0,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        // misaligned load: straight to ERR, no bus request
        vecs[14] = mk(1,0,32'h103,32'h0,       0,0,32'h0,       1,0,1,32'h200,32'h12345678,0,0,32'hDEADBEEF);
        vecs[15] = mk(1,0,32'h103,32'h0,       0,0,32'h0,       0,0,1,32'h200,32'h12345678,1,1,32'hDEADBEEF);
        vecs[16] = mk(0,0,32'h0,  32'h0,       0,0,32'h0,       0,0,1,32'h200,32'h12345678,0,1,32'hDEADBEEF);
        // zero-wait store: two stall cycles
        vecs[17] = mk(1,1,32'h44, 32'hA5A5A5A5,0,0,32'h0,       1,0,1,32'h200,32'h12345678,0,1,32'hDEADBEEF);
        vecs[18] = mk(1,1,32'h44, 32'hA5A5A5A5,1,0,32'h0,       1,1,1,32'h44, 32'hA5A5A5A5,0,1,32'hDEADBEEF);
        vecs[19] = mk(1,1,32'h44, 32'hA5A5A5A5,0,0,32'h0,       0,0,1,32'h44, 32'hA5A5A5A5,0,1,32'hDEADBEEF);
        vecs[20] = mk(0,0,32'h0,  32'h0,       0,0,32'h0,       0,0,1,32'h44, 32'hA5A5A5A5,0,1,32'hDEADBEEF);

        // Reset state, with req_valid high to show stall follows it.
        drive_idle();
        rst_p = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        chk("rst_stall",   {31'b0, a_stall},  32'd1);
        chk("rst_bv",      {31'b0, a_bv},     32'd0);
        chk("rst_rd",      a_rd,              32'd0);
        chk("rst_ba",      a_ba,              32'd0);
        chk("rst_sticky",  {31'b0, a_sticky}, 32'd0);
        $display("reset: stall=%b bv=%b rd=%h", a_stall, a_bv, a_rd);
        do_reset();

        // Table-driven sequence on the default-timeout instance.
        for (int i = 0; i < 21; i++) begin
            req_valid = vecs[i].rv;   req_write  = vecs[i].wr;
            req_addr  = vecs[i].addr; req_wdata  = vecs[i].wdata;
            bus_ready = vecs[i].rdy;  bus_rvalid = vecs[i].rvld;
            bus_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i),  {31'b0, a_stall},  {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d_bv", i),     {31'b0, a_bv},     {31'b0, vecs[i].e_bv});
            chk($sformatf("v%0d_bw", i),     {31'b0, a_bw},     {31'b0, vecs[i].e_bw});
            chk($sformatf("v%0d_ba", i),     a_ba,              vecs[i].e_ba);
            chk($sformatf("v%0d_bwd", i),    a_bwd,             vecs[i].e_bwd);
            chk($sformatf("v%0d_err", i),    {31'b0, a_err},    {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_sticky", i), {31'b0, a_sticky}, {31'b0, vecs[i].e_sticky});
            chk($sformatf("v%0d_rd", i),     a_rd,              vecs[i].e_rd);
            $display("vec %0d: rv=%b wr=%b addr=%h -> stall=%b bv=%b ba=%h err=%b rd=%h",
                     i, vecs[i].rv, vecs[i].wr, vecs[i].addr, a_stall, a_bv, a_ba, a_err, a_rd);
            tick();
        end

        // Timeout in ADDR (limit 4): bus_valid 4 cycles, then ERR pulse.
        do_reset();
        req_valid = 1'b1; req_addr = 32'h40;
        @(negedge clk);
        chk("to_idle_stall", {31'b0, b_stall}, 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_addr%0d_bv", k),  {31'b0, b_bv},  32'd1);
            chk($sformatf("to_addr%0d_err", k), {31'b0, b_err}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("to_err",        {31'b0, b_err},    32'd1);
        chk("to_err_bv",     {31'b0, b_bv},     32'd0);
        chk("to_err_stall",  {31'b0, b_stall},  32'd0);
        chk("to_err_sticky", {31'b0, b_sticky}, 32'd1);
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("to_idle_err",    {31'b0, b_err},    32'd0);
        chk("to_idle_sticky", {31'b0, b_sticky}, 32'd1);
        chk("to_idle_stall2", {31'b0, b_stall},  32'd0);
        $display("timeout addr: err pulse seen, sticky=%b", b_sticky);

        // Timeout in RDATA (limit 4): ADDR 1 cycle, RDATA 3 cycles, ERR.
        do_reset();
        req_valid = 1'b1; req_addr = 32'hC0;
        tick();
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("tr_rd%0d_stall", k), {31'b0, b_stall}, 32'd1);
            chk($sformatf("tr_rd%0d_err", k),   {31'b0, b_err},   32'd0);
            tick();
        end
        @(negedge clk);
        chk("tr_err",    {31'b0, b_err}, 32'd1);
        chk("tr_err_rd", b_rd,           32'd0);
        req_valid = 1'b0;
        $display("timeout rdata: err=%b rd=%h", b_err, b_rd);
        tick();

        // Completion on the last allowed cycle (count = 3) wins over timeout.
        do_reset();
        req_valid = 1'b1; req_addr = 32'h80;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("cl_addr%0d_bv", k), {31'b0, b_bv}, 32'd1);
            tick();
        end
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("cl_done_err",    {31'b0, b_err},    32'd0);
        chk("cl_done_stall",  {31'b0, b_stall},  32'd0);
        chk("cl_done_rd",     b_rd,              32'hCAFEF00D);
        chk("cl_done_sticky", {31'b0, b_sticky}, 32'd0);
        req_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("cl_after_err", {31'b0, b_err}, 32'd0);
        $display("late completion: rd=%h err=%b", b_rd, b_err);

        // Reset while in RDATA abandons the access.
        do_reset();
        req_valid = 1'b1; req_addr = 32'h300;
        tick();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; req_addr = 32'h304;
        @(negedge clk);
        chk("rr_done_rd", a_rd, 32'h55AA55AA);
        tick();
        tick();
        bus_ready = 1'b1;
        @(negedge clk);
        chk("rr_addr_ba", a_ba, 32'h304);
        tick();
        bus_ready = 1'b0;
        @(negedge clk);
        chk("rr_rdata_bv",    {31'b0, a_bv},    32'd0);
        chk("rr_rdata_stall", {31'b0, a_stall}, 32'd1);
        rst_p = 1'b1;
        #1;
        chk("rr_rst_ba",  a_ba,           32'd0);
        chk("rr_rst_rd",  a_rd,           32'd0);
        chk("rr_rst_bv",  {31'b0, a_bv},  32'd0);
        chk("rr_rst_err", {31'b0, a_err}, 32'd0);
        req_valid = 1'b0;
        #1;
        chk("rr_rst_stall", {31'b0, a_stall}, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h77777777;
        tick();
        @(negedge clk);
        rst_p = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("rr_post%0d_rd", k),     a_rd,              32'd0);
            chk($sformatf("rr_post%0d_err", k),    {31'b0, a_err},    32'd0);
            chk($sformatf("rr_post%0d_sticky", k), {31'b0, a_sticky}, 32'd0);
            chk($sformatf("rr_post%0d_stall", k),  {31'b0, a_stall},  32'd0);
        end
        bus_rvalid = 1'b0;
        $display("reset in rdata: rd=%h err=%b", a_rd, a_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm_dmem_bridge.md
SM_DMEM_BRIDGE -- requirements
Module: sm_dmem_bridge

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 255, max cycles spent in ADDR+RDATA before abort (range 2..255).
REQ-002 The block SHALL have these ports, in this order:
- clk  in  1  single clock, rising edge
- rst_p  in  1  asynchronous, active-high reset
- req_valid  in  1  core requests data access this cycle (load or store)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data
- stall  out  1  core SHALL hold PC and request while high
- rsp_rdata  out  32  load data to result mux
- err  out  1  one-cycle pulse: misaligned or timed-out access
- err_sticky  out  1  set on any err, cleared only by reset
- bus_valid  out  1  request to memory
- bus_write  out  1  request type
- bus_addr  out  32  word-aligned address
- bus_wdata  out  32  write data
- bus_ready  in  1  memory accepts request
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data
REQ-003 Clock and reset SHALL be: one clock (clk); reset is asynchronous and active-high (rst_p).

Function
REQ-004 FSM states SHALL be IDLE, ADDR, RDATA, DONE, ERR.
REQ-005 IDLE: req_valid=1 with req_addr[1:0]=0 SHALL go to ADDR; with req_addr[1:0]!=0 SHALL go to ERR without any bus request; req_valid=0 SHALL stay.
REQ-006 ADDR: bus_valid=1 with bus_write/bus_addr/bus_wdata registered from the request on the IDLE->ADDR edge; held stable until bus_ready=1.
REQ-007 ADDR, bus_ready=1: store SHALL go to DONE; load with bus_rvalid=1 same cycle SHALL capture bus_rdata and go to DONE; load otherwise SHALL go to RDATA.
REQ-008 RDATA: bus_valid=0; bus_rvalid=1 SHALL capture bus_rdata into rsp_rdata and go to DONE.
REQ-009 DONE and ERR SHALL last exactly one cycle, then IDLE; request inputs are ignored in these states.
REQ-010 stall SHALL be combinational: 1 when (IDLE and req_valid) or state is ADDR or RDATA; 0 in DONE, ERR, and idle-without-request.
REQ-011 err SHALL be 1 only in ERR; err_sticky SHALL set on the ERR-entry edge.
REQ-012 rsp_rdata SHALL be a register updated only on load capture, holding its value otherwise; ERR SHALL not modify it.
REQ-013 An 8-bit wait counter SHALL clear on IDLE->ADDR and increment each cycle in ADDR or RDATA; when count = TIMEOUT_CYCLES-1 and the completing condition of REQ-007/REQ-008 is absent, the FSM SHALL go to ERR and drop bus_valid the next cycle.
REQ-014 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-015 Zero-wait load latency SHALL be: IDLE (stall) -> ADDR (ready) -> RDATA (rvalid) -> DONE (stall=0, data valid), i.e. 3 stall cycles; zero-wait store 2 stall cycles.
REQ-016 bus_rvalid outside RDATA/ADDR-load SHALL be ignored.

Reset
REQ-017 rst_p=1 SHALL asynchronously force state=IDLE, counter=0, bus_valid=0, bus_write=0, bus_addr=0, bus_wdata=0, rsp_rdata=0, err=0, err_sticky=0; stall then follows REQ-010 (=req_valid).
REQ-018 Reset mid-transaction SHALL abandon it; no DONE or err follows.

Structure
REQ-019 State enum and TIMEOUT_DEFAULT SHALL live in package sm_dmem_pkg.
REQ-020 The wait counter SHALL be sub-module sm_timeout_counter (clear, enable, limit in; expired out); all else in one module.

Verification
REQ-021 Load 0x100, bus_ready=1 in ADDR, bus_rvalid=1 one cycle later with 0xDEADBEEF -> stall high 3 cycles, rsp_rdata=0xDEADBEEF in DONE, err=0.
REQ-022 Store 0x200/0x12345678, bus_ready delayed 4 cycles -> bus_valid held 5 cycles with stable bus_addr=0x200, bus_wdata=0x12345678; DONE follows; rsp_rdata unchanged.
REQ-023 Load 0x103 -> bus_valid never asserts, next cycle ERR: err=1, stall=0, err_sticky=1 thereafter.
REQ-024 TIMEOUT_CYCLES=4, bus_ready never asserted -> bus_valid high 4 cycles, then ERR pulse, bus_valid=0, back to IDLE.
REQ-025 Completion on count=TIMEOUT_CYCLES-1 -> DONE, no err; rst_p pulse while in RDATA -> immediate IDLE, bus_valid=0, rsp_rdata=0, no DONE/err.
